complex_block_mac_seq: RTL and testbench

- Hardware sequencer that computes C = A*B, C = D + A*B or C = D - A*B on SIZE x SIZE complex double-precision matrices.
- Replaces the bench-side element loops that feed complex_matrix_mul and complex_add during block-LU Schur-complement updates.
- Fetches A rows, B columns and D rows over row-read ports, then drives an external complex_matrix_mul (dot product) and an external complex_add over valid/ready handshakes.
- Streams C out element by element in row-major order.

---
 rtl/complex_block_mac_seq.sv | 184 ++++++++++++++++++
 tb/tb_complex_block_mac_seq.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_block_mac_seq.sv
`timescale 1ns/1ps
// Sequencer for C = A*B, D + A*B or D - A*B on complex matrices.
// Fetches rows/columns, drives external dot-product and add units, streams C.
module complex_block_mac_seq #(
  parameter int SIZE  = 4,
  parameter int WIDTH = 64,
  localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1,
  localparam int RW = SIZE * 2 * WIDTH,
  localparam int CW = 2 * WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  start,
  input  logic [1:0]            mode_i,
  output logic                  in_ready_o,
  output logic                  busy_o,
  output logic [AW-1:0]         a_row_addr_o,
  output logic                  a_row_addr_valid_o,
  input  logic [RW-1:0]         a_row_i,
  input  logic                  a_row_valid_i,
  output logic [AW-1:0]         b_col_addr_o,
  output logic                  b_col_addr_valid_o,
  input  logic [RW-1:0]         b_col_i,
  input  logic                  b_col_valid_i,
  output logic [AW-1:0]         d_row_addr_o,
  output logic                  d_row_addr_valid_o,
  input  logic [RW-1:0]         d_row_i,
  input  logic                  d_row_valid_i,
  output logic [SIZE*4*WIDTH-1:0] dp_operands_o,
  output logic                  dp_valid_o,
  input  logic                  dp_ready_i,
  input  logic [CW-1:0]         dp_result_i,
  input  logic                  dp_result_valid_i,
  output logic [4*WIDTH-1:0]    add_operands_o,
  output logic                  add_sub_o,
  output logic                  add_valid_o,
  input  logic                  add_ready_i,
  input  logic [CW-1:0]         add_result_i,
  input  logic                  add_result_valid_i,
  output logic [CW-1:0]         c_elem_o,
  output logic [AW-1:0]         c_row_o,
  output logic [AW-1:0]         c_col_o,
  output logic                  c_valid_o,
  input  logic                  c_ready_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_ROW, S_FETCH_COL, S_DP_ISSUE,
    S_DP_WAIT, S_ADD_ISSUE, S_ADD_WAIT, S_WRITE
  } state_t;

  state_t r_state, w_next;
  logic r_first;
  logic r_mac, r_sub;
  logic [AW-1:0] r_i, r_j;
  logic r_have_a, r_have_d;
  logic [RW-1:0] r_arow, r_drow, r_bcol;
  logic [CW-1:0] r_prod, r_c;
  logic w_got_a, w_got_d, w_last_col, w_last_row;

  assign w_last_col = (r_j == AW'(SIZE - 1));
  assign w_last_row = (r_i == AW'(SIZE - 1));
  // Return strobes are never expected in the request cycle itself.
  assign w_got_a = r_have_a | (a_row_valid_i & ~r_first);
  assign w_got_d = ~r_mac | r_have_d | (d_row_valid_i & ~r_first);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:      if (start) w_next = S_FETCH_ROW;
      S_FETCH_ROW: if (w_got_a && w_got_d) w_next = S_FETCH_COL;
      S_FETCH_COL: if (b_col_valid_i && !r_first) w_next = S_DP_ISSUE;
      S_DP_ISSUE:  if (dp_ready_i) w_next = S_DP_WAIT;
      S_DP_WAIT:
        if (dp_result_valid_i) w_next = r_mac ? S_ADD_ISSUE : S_WRITE;
      S_ADD_ISSUE: if (add_ready_i) w_next = S_ADD_WAIT;
      S_ADD_WAIT:  if (add_result_valid_i) w_next = S_WRITE;
      S_WRITE:
        if (c_ready_i) begin
          if (!w_last_col)      w_next = S_FETCH_COL;
          else if (!w_last_row) w_next = S_FETCH_ROW;
          else                  w_next = S_IDLE;
        end
      default: w_next = S_IDLE;
    endcase
    if (flush_i) w_next = S_IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_first  <= 1'b0;
      r_mac    <= 1'b0;
      r_sub    <= 1'b0;
      r_i      <= '0;
      r_j      <= '0;
      r_have_a <= 1'b0;
      r_have_d <= 1'b0;
      r_arow   <= '0;
      r_drow   <= '0;
      r_bcol   <= '0;
      r_prod   <= '0;
      r_c      <= '0;
    end else begin
      r_state <= w_next;
      r_first <= (w_next != r_state);
      if (r_state != S_FETCH_ROW) begin
        r_have_a <= 1'b0;
        r_have_d <= 1'b0;
      end
      unique case (r_state)
        S_IDLE:
          if (start && !flush_i) begin
            r_mac <= (mode_i == 2'b01) || (mode_i == 2'b10);
            r_sub <= (mode_i == 2'b10);
            r_i   <= '0;
            r_j   <= '0;
          end
        S_FETCH_ROW:
          if (!r_first) begin
            if (a_row_valid_i) begin
              r_arow   <= a_row_i;
              r_have_a <= 1'b1;
            end
            if (d_row_valid_i && r_mac) begin
              r_drow   <= d_row_i;
              r_have_d <= 1'b1;
            end
          end
        S_FETCH_COL:
          if (b_col_valid_i && !r_first) r_bcol <= b_col_i;
        S_DP_WAIT:
          if (dp_result_valid_i) begin
            r_prod <= dp_result_i;
            if (!r_mac) r_c <= dp_result_i;
          end
        S_ADD_WAIT:
          if (add_result_valid_i) r_c <= add_result_i;
        S_WRITE:
          if (c_ready_i && !flush_i) begin
            if (!w_last_col) begin
              r_j <= r_j + AW'(1);
            end else if (!w_last_row) begin
              r_j <= '0;
              r_i <= r_i + AW'(1);
            end
          end
        default: ;
      endcase
    end
  end

  assign in_ready_o = (r_state == S_IDLE);
  assign busy_o     = ~in_ready_o;

  assign a_row_addr_o       = r_i;
  assign a_row_addr_valid_o = (r_state == S_FETCH_ROW) && r_first;
  assign d_row_addr_o       = r_i;
  assign d_row_addr_valid_o = (r_state == S_FETCH_ROW) && r_first && r_mac;
  assign b_col_addr_o       = r_j;
  assign b_col_addr_valid_o = (r_state == S_FETCH_COL) && r_first;

  always_comb begin
    dp_operands_o = '0;
    for (int k = 0; k < SIZE; k++) begin
      dp_operands_o[(4*k+0)*WIDTH +: WIDTH] = r_arow[(2*k+0)*WIDTH +: WIDTH];
      dp_operands_o[(4*k+1)*WIDTH +: WIDTH] = r_arow[(2*k+1)*WIDTH +: WIDTH];
      dp_operands_o[(4*k+2)*WIDTH +: WIDTH] = r_bcol[(2*k+0)*WIDTH +: WIDTH];
      dp_operands_o[(4*k+3)*WIDTH +: WIDTH] = r_bcol[(2*k+1)*WIDTH +: WIDTH];
    end
  end
  assign dp_valid_o = (r_state == S_DP_ISSUE);

  assign add_operands_o = {r_prod, r_drow[int'(r_j)*CW +: CW]};
  assign add_valid_o    = (r_state == S_ADD_ISSUE);
  assign add_sub_o      = r_sub && add_valid_o;

  assign c_elem_o  = r_c;
  assign c_row_o   = r_i;
  assign c_col_o   = r_j;
  assign c_valid_o = (r_state == S_WRITE);

endmodule

// File: tb/tb_complex_block_mac_seq.sv
`timescale 1ns/1ps
// Bench for complex_block_mac_seq: memory/unit responders plus a matrix
// reference model whose expected C stream is checked on every write.
module tb_complex_block_mac_seq;
  localparam int SZ = 4;
  localparam int W  = 64;
  localparam int AW = 2;
  localparam int RW = SZ * 2 * W;
  localparam int CW = 2 * W;
  localparam int OW = SZ * 4 * W;

  logic clk_i, rst_i, flush_i, start;
  logic [1:0] mode_i;
  logic in_ready_o, busy_o;
  logic [AW-1:0] a_row_addr_o, b_col_addr_o, d_row_addr_o;
  logic a_row_addr_valid_o, b_col_addr_valid_o, d_row_addr_valid_o;
  logic [RW-1:0] a_row_i, b_col_i, d_row_i;
  logic a_row_valid_i, b_col_valid_i, d_row_valid_i;
  logic [OW-1:0] dp_operands_o;
  logic dp_valid_o, dp_ready_i, dp_result_valid_i;
  logic [CW-1:0] dp_result_i;
  logic [4*W-1:0] add_operands_o;
  logic add_sub_o, add_valid_o, add_ready_i, add_result_valid_i;
  logic [CW-1:0] add_result_i;
  logic [CW-1:0] c_elem_o;
  logic [AW-1:0] c_row_o, c_col_o;
  logic c_valid_o, c_ready_i;

  complex_block_mac_seq #(.SIZE(SZ), .WIDTH(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .start(start),
    .mode_i(mode_i), .in_ready_o(in_ready_o), .busy_o(busy_o),
    .a_row_addr_o(a_row_addr_o), .a_row_addr_valid_o(a_row_addr_valid_o),
    .a_row_i(a_row_i), .a_row_valid_i(a_row_valid_i),
    .b_col_addr_o(b_col_addr_o), .b_col_addr_valid_o(b_col_addr_valid_o),
    .b_col_i(b_col_i), .b_col_valid_i(b_col_valid_i),
    .d_row_addr_o(d_row_addr_o), .d_row_addr_valid_o(d_row_addr_valid_o),
    .d_row_i(d_row_i), .d_row_valid_i(d_row_valid_i),
    .dp_operands_o(dp_operands_o), .dp_valid_o(dp_valid_o),
    .dp_ready_i(dp_ready_i), .dp_result_i(dp_result_i),
    .dp_result_valid_i(dp_result_valid_i),
    .add_operands_o(add_operands_o), .add_sub_o(add_sub_o),
    .add_valid_o(add_valid_o), .add_ready_i(add_ready_i),
    .add_result_i(add_result_i), .add_result_valid_i(add_result_valid_i),
    .c_elem_o(c_elem_o), .c_row_o(c_row_o), .c_col_o(c_col_o),
    .c_valid_o(c_valid_o), .c_ready_i(c_ready_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct { int r; int c; logic [CW-1:0] v; } exp_t;
  exp_t expq[$];

  real ar[SZ][SZ], ai[SZ][SZ];
  real br[SZ][SZ], bi[SZ][SZ];
  real dr[SZ][SZ], di[SZ][SZ];

  int total, bad;
  int lat_max;
  bit stall;
  bit exp_sub;
  int na, nb, nd, nwr;
  int first_a;

  task automatic chk_v(input string nm, input logic [OW-1:0] act,
                       input logic [OW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  function automatic logic [CW-1:0] cplx(input real re, input real im);
    return {$realtobits(im), $realtobits(re)};
  endfunction

  function automatic int lat();
    if (lat_max <= 1) return 1;
    return int'($urandom_range(lat_max, 1));
  endfunction

  function automatic bit rdy();
    if (!stall) return 1'b1;
    return ($urandom_range(2, 0) != 0);
  endfunction

  // sel 0: A row, 1: B column, 2: D row
  function automatic logic [RW-1:0] pack(input int sel, input int idx);
    logic [RW-1:0] v;
    v = '0;
    for (int k = 0; k < SZ; k++) begin
      if (sel == 0) v[k*CW +: CW] = cplx(ar[idx][k], ai[idx][k]);
      else if (sel == 1) v[k*CW +: CW] = cplx(br[k][idx], bi[k][idx]);
      else v[k*CW +: CW] = cplx(dr[idx][k], di[idx][k]);
    end
    return v;
  endfunction

  task automatic build_exp(input logic [1:0] mode);
    real pr, pi;
    exp_t e;
    expq.delete();
    for (int r = 0; r < SZ; r++)
      for (int c = 0; c < SZ; c++) begin
        pr = 0.0;
        pi = 0.0;
        for (int k = 0; k < SZ; k++) begin
          pr += ar[r][k] * br[k][c] - ai[r][k] * bi[k][c];
          pi += ar[r][k] * bi[k][c] + ai[r][k] * br[k][c];
        end
        e.r = r;
        e.c = c;
        if (mode == 2'd1) e.v = cplx(dr[r][c] + pr, di[r][c] + pi);
        else if (mode == 2'd2) e.v = cplx(dr[r][c] - pr, di[r][c] - pi);
        else e.v = cplx(pr, pi);
        expq.push_back(e);
      end
  endtask

  task automatic set_real_ab(input real dval);
    for (int r = 0; r < SZ; r++)
      for (int c = 0; c < SZ; c++) begin
        ar[r][c] = 0.0; ai[r][c] = 0.0;
        br[r][c] = 0.0; bi[r][c] = 0.0;
        dr[r][c] = dval; di[r][c] = 0.0;
      end
    ar[0][0] = 1.0; ar[0][1] = 2.0; ar[1][0] = 3.0; ar[1][1] = 4.0;
    br[0][0] = 5.0; br[0][1] = 6.0; br[1][0] = 7.0; br[1][1] = 8.0;
  endtask

  task automatic set_cplx();
    for (int r = 0; r < SZ; r++)
      for (int c = 0; c < SZ; c++) begin
        ar[r][c] = (r == c) ? 1.0 : 0.0;
        ai[r][c] = (r == c) ? 1.0 : 0.0;
        br[r][c] = 2.0; bi[r][c] = 0.0;
        dr[r][c] = 0.0; di[r][c] = 3.0;
      end
  endtask

  task automatic launch(input logic [1:0] mode);
    na = 0; nb = 0; nd = 0; nwr = 0;
    exp_sub = (mode == 2'd2);
    mode_i = mode;
    start = 1'b1;
    @(negedge clk_i);
    start = 1'b0;
    mode_i = 2'b11;
  endtask

  task automatic go(input logic [1:0] mode, input bit extra);
    int cyc;
    launch(mode);
    cyc = 0;
    while (!(expq.size() == 0 && in_ready_o) && cyc < 5000) begin
      start = extra && busy_o && (cyc % 7 == 0);
      @(negedge clk_i);
      cyc++;
    end
    start = 1'b0;
    chk_i("run_timeout", int'(cyc < 5000), 1);
    chk_i("a_fetch", na, SZ);
    chk_i("b_fetch", nb, SZ * SZ);
    chk_i("d_fetch", nd, (mode == 2'd1 || mode == 2'd2) ? SZ : 0);
    chk_i("done_ready", int'(in_ready_o), 1);
  endtask

  // Row/column memories
  initial begin : mem_a
    int cnt, adr;
    cnt = 0; adr = 0;
    a_row_valid_i = 1'b0; a_row_i = '0;
    forever begin
      @(negedge clk_i);
      a_row_valid_i = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin a_row_valid_i = 1'b1; a_row_i = pack(0, adr); end
      end
      if (a_row_addr_valid_o && !rst_i) begin
        if (na == 0) first_a = int'(a_row_addr_o);
        na++;
        adr = int'(a_row_addr_o);
        cnt = lat();
      end
    end
  end

  initial begin : mem_b
    int cnt, adr;
    cnt = 0; adr = 0;
    b_col_valid_i = 1'b0; b_col_i = '0;
    forever begin
      @(negedge clk_i);
      b_col_valid_i = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin b_col_valid_i = 1'b1; b_col_i = pack(1, adr); end
      end
      if (b_col_addr_valid_o && !rst_i) begin
        nb++;
        adr = int'(b_col_addr_o);
        cnt = lat();
      end
    end
  end

  initial begin : mem_d
    int cnt, adr;
    cnt = 0; adr = 0;
    d_row_valid_i = 1'b0; d_row_i = '0;
    forever begin
      @(negedge clk_i);
      d_row_valid_i = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin d_row_valid_i = 1'b1; d_row_i = pack(2, adr); end
      end
      if (d_row_addr_valid_o && !rst_i) begin
        nd++;
        adr = int'(d_row_addr_o);
        cnt = lat();
      end
    end
  end

  // Dot-product unit
  initial begin : dp_unit
    int cnt;
    bit hold;
    logic [OW-1:0] last;
    logic [CW-1:0] res;
    real sr, si, a_re, a_im, b_re, b_im;
    cnt = 0; hold = 1'b0; last = '0; res = '0;
    dp_ready_i = 1'b0; dp_result_valid_i = 1'b0; dp_result_i = '0;
    forever begin
      @(negedge clk_i);
      dp_result_valid_i = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin dp_result_valid_i = 1'b1; dp_result_i = res; end
      end
      if (dp_valid_o && hold && !rst_i) chk_v("dp_hold", dp_operands_o, last);
      dp_ready_i = rdy();
      if (dp_valid_o && dp_ready_i && !rst_i) begin
        sr = 0.0; si = 0.0;
        for (int k = 0; k < SZ; k++) begin
          a_re = $bitstoreal(dp_operands_o[(4*k+0)*W +: W]);
          a_im = $bitstoreal(dp_operands_o[(4*k+1)*W +: W]);
          b_re = $bitstoreal(dp_operands_o[(4*k+2)*W +: W]);
          b_im = $bitstoreal(dp_operands_o[(4*k+3)*W +: W]);
          sr += a_re * b_re - a_im * b_im;
          si += a_re * b_im + a_im * b_re;
        end
        res = cplx(sr, si);
        cnt = lat();
      end
      hold = dp_valid_o && !dp_ready_i;
      last = dp_operands_o;
    end
  end

  // Complex adder unit
  initial begin : add_unit
    int cnt;
    bit hold;
    logic [4*W:0] last;
    logic [CW-1:0] res;
    real d_re, d_im, p_re, p_im;
    cnt = 0; hold = 1'b0; last = '0; res = '0;
    add_ready_i = 1'b0; add_result_valid_i = 1'b0; add_result_i = '0;
    forever begin
      @(negedge clk_i);
      add_result_valid_i = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin add_result_valid_i = 1'b1; add_result_i = res; end
      end
      if (add_valid_o && hold && !rst_i)
        chk_v("add_hold", OW'({add_sub_o, add_operands_o}), OW'(last));
      add_ready_i = rdy();
      if (add_valid_o && add_ready_i && !rst_i) begin
        chk_i("add_sub", int'(add_sub_o), int'(exp_sub));
        d_re = $bitstoreal(add_operands_o[0*W +: W]);
        d_im = $bitstoreal(add_operands_o[1*W +: W]);
        p_re = $bitstoreal(add_operands_o[2*W +: W]);
        p_im = $bitstoreal(add_operands_o[3*W +: W]);
        if (add_sub_o) res = cplx(d_re - p_re, d_im - p_im);
        else res = cplx(d_re + p_re, d_im + p_im);
        cnt = lat();
      end
      hold = add_valid_o && !add_ready_i;
      last = {add_sub_o, add_operands_o};
    end
  end

  // Output compare against the model queue
  initial begin : c_check
    bit hold;
    logic [CW+2*AW-1:0] last;
    exp_t e;
    hold = 1'b0; last = '0;
    c_ready_i = 1'b0;
    forever begin
      @(negedge clk_i);
      c_ready_i = rdy();
      if (c_valid_o && !rst_i) begin
        if (hold)
          chk_v("c_hold", OW'({c_row_o, c_col_o, c_elem_o}), OW'(last));
        if (c_ready_i) begin
          nwr++;
          if (expq.size() == 0) begin
            total++; bad++;
            $display("FAIL c_unexpected: got write (%0d,%0d) want none",
                     c_row_o, c_col_o);
          end else begin
            e = expq.pop_front();
            chk_i("c_row", int'(c_row_o), e.r);
            chk_i("c_col", int'(c_col_o), e.c);
            chk_v("c_elem", OW'(c_elem_o), OW'(e.v));
          end
        end
      end
      hold = c_valid_o && !c_ready_i;
      last = {c_row_o, c_col_o, c_elem_o};
    end
  end

  initial begin : main
    int cyc;
    total = 0; bad = 0; lat_max = 1; stall = 1'b0; exp_sub = 1'b0;
    na = 0; nb = 0; nd = 0; nwr = 0; first_a = -1;
    rst_i = 1'b1; flush_i = 1'b0; start = 1'b0; mode_i = 2'b00;
    #12;
    chk_i("rst_in_ready", int'(in_ready_o), 1);
    chk_i("rst_busy", int'(busy_o), 0);
    chk_i("rst_valids", int'({a_row_addr_valid_o, b_col_addr_valid_o,
          d_row_addr_valid_o, dp_valid_o, add_valid_o, c_valid_o,
          add_sub_o}), 0);
    chk_v("rst_c", OW'({c_row_o, c_col_o, c_elem_o}), '0);
    chk_v("rst_dp_ops", dp_operands_o, '0);
    chk_v("rst_add_ops", OW'(add_operands_o), '0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    // MUL, no stalls
    set_real_ab(0.0);
    build_exp(2'd0);
    chk_v("model_mul00", OW'(expq[0].v), OW'(cplx(19.0, 0.0)));
    chk_v("model_mul01", OW'(expq[1].v), OW'(cplx(22.0, 0.0)));
    chk_v("model_mul10", OW'(expq[4].v), OW'(cplx(43.0, 0.0)));
    chk_v("model_mul11", OW'(expq[5].v), OW'(cplx(50.0, 0.0)));
    go(2'd0, 1'b0);

    // MAC_SUB, no stalls
    set_real_ab(100.0);
    build_exp(2'd2);
    chk_v("model_sub00", OW'(expq[0].v), OW'(cplx(81.0, 0.0)));
    chk_v("model_sub01", OW'(expq[1].v), OW'(cplx(78.0, 0.0)));
    chk_v("model_sub10", OW'(expq[4].v), OW'(cplx(57.0, 0.0)));
    chk_v("model_sub02", OW'(expq[2].v), OW'(cplx(100.0, 0.0)));
    go(2'd2, 1'b0);

    // MAC_ADD complex, with start pulses while busy
    set_cplx();
    build_exp(2'd1);
    chk_v("model_add00", OW'(expq[0].v), OW'(cplx(2.0, 5.0)));
    chk_v("model_add33", OW'(expq[15].v), OW'(cplx(2.0, 5.0)));
    go(2'd1, 1'b1);

    // Backpressure and variable latency
    stall = 1'b1; lat_max = 5;
    set_real_ab(0.0);
    build_exp(2'd0);
    go(2'd0, 1'b0);
    set_real_ab(100.0);
    build_exp(2'd2);
    go(2'd2, 1'b0);
    set_cplx();
    build_exp(2'd1);
    go(2'd1, 1'b0);

    // Flush while working on element (1,0)
    lat_max = 3;
    set_real_ab(0.0);
    build_exp(2'd0);
    launch(2'd0);
    cyc = 0;
    while (nwr < SZ && cyc < 2000) begin @(negedge clk_i); cyc++; end
    while (!dp_valid_o && cyc < 2000) begin @(negedge clk_i); cyc++; end
    chk_i("flush_reach", int'(cyc < 2000), 1);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    chk_i("flush_idle", int'(in_ready_o), 1);
    chk_i("flush_valids", int'({dp_valid_o, add_valid_o, c_valid_o}), 0);
    expq.delete();
    nwr = 0;
    repeat (20) @(negedge clk_i);
    chk_i("flush_no_write", nwr, 0);
    first_a = -1;
    build_exp(2'd0);
    go(2'd0, 1'b0);
    chk_i("flush_restart_a0", first_a, 0);

    // Reset while waiting for a dot-product result
    stall = 1'b0; lat_max = 5;
    set_real_ab(100.0);
    build_exp(2'd1);
    launch(2'd1);
    cyc = 0;
    while (!(dp_valid_o && dp_ready_i) && cyc < 2000) begin
      @(negedge clk_i); cyc++;
    end
    chk_i("rst_reach", int'(cyc < 2000), 1);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    #1;
    chk_i("midrst_valids", int'({a_row_addr_valid_o, b_col_addr_valid_o,
          d_row_addr_valid_o, dp_valid_o, add_valid_o, c_valid_o,
          add_sub_o}), 0);
    chk_i("midrst_ready", int'(in_ready_o), 1);
    @(negedge clk_i);
    rst_i = 1'b0;
    expq.delete();
    nwr = 0;
    repeat (12) @(negedge clk_i);
    chk_i("midrst_no_write", nwr, 0);
    chk_i("midrst_in_ready", int'(in_ready_o), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
